// File: rtl/cnn_acc_ci_seq.sv
// Purpose: accumulates per-channel-group kernel partial sums over a tile of beats into one output tile.
// Latency: result registered 1 cycle after the last accepted beat; no bubble between back-to-back tiles.
// Backpressure: o_in_ready follows i_ot_ready while a result waits; result is held until i_ot_ready.
// Optional macro CNN_ACC_SAT_EN: saturate output pixels to DATA_LEN signed range (default: truncate).
module cnn_acc_ci_seq #(
  parameter int OX        = 3,
  parameter int OY        = 3,
  parameter int DATA_LEN  = 8,
  parameter int ACC_LEN   = 20,
  parameter int PCH       = 4,
  parameter int MAX_BEATS = 16,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_soft_reset,
  input  logic [CNT_W-1:0]             i_num_beats,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [PCH*OX*OY*DATA_LEN-1:0] i_in_psum,
  output logic                         o_ot_valid,
  input  logic                         i_ot_ready,
  output logic [OX*OY*DATA_LEN-1:0]    o_ot_ci_acc,
  output logic                         o_busy
);

  localparam int NPIX = OX * OY;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                       w_accept;
  logic                       w_start;
  logic                       w_add;
  logic                       w_to_out;
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           r_nb;
  logic [CNT_W-1:0]           w_nb_new;
  logic [CNT_W-1:0]           w_cnt_inc;
  logic signed [ACC_LEN-1:0]  r_acc     [NPIX];
  logic signed [ACC_LEN-1:0]  w_bsum    [NPIX];
  logic signed [ACC_LEN-1:0]  w_acc_nxt [NPIX];
  logic [DATA_LEN-1:0]        w_pix     [NPIX];
  logic [NPIX*DATA_LEN-1:0]   r_ot_ci_acc;

  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign o_busy      = (r_state != IDLE);
  assign o_ot_valid  = (r_state == OUT);
  assign o_ot_ci_acc = r_ot_ci_acc;

  // Beat count for a new tile: zero means one beat, oversize clamps to MAX_BEATS
  always_comb begin
    if (i_num_beats == '0) begin
      w_nb_new = CNT_W'(1);
    end else if (i_num_beats > CNT_W'(MAX_BEATS)) begin
      w_nb_new = CNT_W'(MAX_BEATS);
    end else begin
      w_nb_new = i_num_beats;
    end
  end

  // Per-pixel datapath: lane sum, next accumulator value, output formatting
  for (genvar p = 0; p < NPIX; p++) begin : g_pix
    // Sign-extended sum of all PCH lanes for this pixel
    always_comb begin
      w_bsum[p] = '0;
      for (int c = 0; c < PCH; c++) begin
        w_bsum[p] = w_bsum[p] + ACC_LEN'($signed(i_in_psum[(c*NPIX+p)*DATA_LEN +: DATA_LEN]));
      end
    end

    // First beat of a tile loads, later beats add (wraps modulo 2^ACC_LEN)
    always_comb begin
      w_acc_nxt[p] = w_start ? w_bsum[p] : (r_acc[p] + w_bsum[p]);
    end

`ifdef CNN_ACC_SAT_EN
    logic [ACC_LEN-DATA_LEN:0] w_hi;
    assign w_hi = w_acc_nxt[p][ACC_LEN-1:DATA_LEN-1];

    // Saturate when the bits above the output sign bit are not a pure sign extension
    always_comb begin
      if ((&w_hi) || !(|w_hi)) begin
        w_pix[p] = w_acc_nxt[p][DATA_LEN-1:0];
      end else if (w_acc_nxt[p][ACC_LEN-1]) begin
        w_pix[p] = {1'b1, {(DATA_LEN-1){1'b0}}};
      end else begin
        w_pix[p] = {1'b0, {(DATA_LEN-1){1'b1}}};
      end
    end
`else
    // Plain truncation to the output width
    always_comb begin
      w_pix[p] = w_acc_nxt[p][DATA_LEN-1:0];
    end
`endif
  end

  // State register; soft reset forces IDLE and wins over any beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (i_soft_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, input ready and datapath controls
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    w_start     = 1'b0;
    w_add       = 1'b0;
    w_to_out    = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        w_accept   = i_in_valid && !i_soft_reset;
        w_start    = w_accept;
      end
      ACC: begin
        o_in_ready = 1'b1;
        w_accept   = i_in_valid && !i_soft_reset;
        w_add      = w_accept;
      end
      OUT: begin
        o_in_ready = i_ot_ready;
        w_accept   = i_in_valid && i_ot_ready && !i_soft_reset;
        w_start    = w_accept;
        if (i_ot_ready && !w_accept) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_start) begin
      w_to_out    = (w_nb_new == CNT_W'(1));
      w_state_nxt = w_to_out ? OUT : ACC;
    end else if (w_add) begin
      w_to_out    = (w_cnt_inc == r_nb);
      w_state_nxt = w_to_out ? OUT : ACC;
    end
  end

  // Accumulator, beat counter, tile length and registered result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_nb        <= CNT_W'(1);
      r_ot_ci_acc <= '0;
      for (int p = 0; p < NPIX; p++) r_acc[p] <= '0;
    end else if (i_soft_reset) begin
      r_cnt       <= '0;
      r_nb        <= CNT_W'(1);
      r_ot_ci_acc <= '0;
      for (int p = 0; p < NPIX; p++) r_acc[p] <= '0;
    end else begin
      if (w_start) begin
        r_cnt <= CNT_W'(1);
        r_nb  <= w_nb_new;
      end else if (w_add) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_start || w_add) begin
        for (int p = 0; p < NPIX; p++) r_acc[p] <= w_acc_nxt[p];
      end
      if (w_to_out) begin
        for (int p = 0; p < NPIX; p++) r_ot_ci_acc[p*DATA_LEN +: DATA_LEN] <= w_pix[p];
      end
    end
  end

endmodule
